// File: rtl/dnn_accel_pkg.sv
// Shared definitions for the DNN accelerator data-request path: controller
// state encoding, configuration field offsets and the words-per-line formula.
package dnn_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LEND = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  localparam int unsigned CONF_W_LSB = 0;
  localparam int unsigned CONF_W_MSB = 7;
  localparam int unsigned CONF_H_LSB = 8;
  localparam int unsigned CONF_H_MSB = 15;
  localparam int unsigned CONF_K_LSB = 0;

  // Three bytes per pixel packed into 32-bit words; 255*3 still fits in 10 bits.
  function automatic logic [9:0] calc_words_per_line(input logic [7:0] width);
    logic [9:0] w3;
    w3 = {2'b00, width} * 10'd3;
    return w3 >> 2;
  endfunction

endpackage

// File: rtl/data_req_ctrl_cnt.sv
// Beat / kernel-line / output-row counter chain for data_req_ctrl, with the
// terminal-count flags the controller FSM branches on.
module data_req_ctrl_cnt
  import dnn_accel_pkg::*;
#(
  parameter int unsigned BEAT_CNT_WIDTH    = 10,
  parameter int unsigned KERNEL_SIZE_WIDTH = 2,
  parameter int unsigned ROW_CNT_WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         beat_inc,
  input  logic                         line_end,
  input  logic [BEAT_CNT_WIDTH-1:0]    words_per_line,
  input  logic [KERNEL_SIZE_WIDTH-1:0] kernel_size,
  input  logic [ROW_CNT_WIDTH:0]       out_rows,
  output logic [BEAT_CNT_WIDTH-1:0]    beat_cnt,
  output logic [KERNEL_SIZE_WIDTH-1:0] kline_cnt,
  output logic [ROW_CNT_WIDTH-1:0]     row_cnt,
  output logic                         beat_last,
  output logic                         kline_wrap,
  output logic                         row_last
);

  assign beat_last  = (beat_cnt == words_per_line - BEAT_CNT_WIDTH'(1));
  assign kline_wrap = (kline_cnt == kernel_size - KERNEL_SIZE_WIDTH'(1));
  assign row_last   = ({1'b0, row_cnt} == out_rows - (ROW_CNT_WIDTH + 1)'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beat_cnt  <= '0;
      kline_cnt <= '0;
      row_cnt   <= '0;
    end else if (line_end) begin
      beat_cnt <= '0;
      if (kline_wrap) begin
        kline_cnt <= '0;
        row_cnt   <= row_cnt + ROW_CNT_WIDTH'(1);
      end else begin
        kline_cnt <= kline_cnt + KERNEL_SIZE_WIDTH'(1);
      end
    end else if (beat_inc) begin
      beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/data_req_ctrl.sv
// Layer-pass sequencer for data_req: line bursts, stall pass-through, end-of-line
// strobes. Define DATA_REQ_CTRL_PERF_EN to add stall/busy-cycle perf counters.
module data_req_ctrl
  import dnn_accel_pkg::*;
#(
  parameter int unsigned REG_WIDTH         = 32,
  parameter int unsigned KERNEL_SIZE_WIDTH = 2,
  parameter int unsigned BEAT_CNT_WIDTH    = 10,
  parameter int unsigned ROW_CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_fifo_full,
  input  logic [REG_WIDTH-1:0] i_conf_inputshape,
  input  logic [REG_WIDTH-1:0] i_conf_kernelshape,
  output logic                 o_req,
  output logic                 o_stall,
  output logic                 o_end,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [REG_WIDTH-1:0] dbg_ctrl_state,
  output logic [REG_WIDTH-1:0] dbg_ctrl_cnt
`ifdef DATA_REQ_CTRL_PERF_EN
  ,
  output logic [REG_WIDTH-1:0] o_perf_stall_cnt,
  output logic [REG_WIDTH-1:0] o_perf_cycle_cnt
`endif
);

  ctrl_state_e state_q, state_d;

  logic [7:0]                   conf_w, conf_h;
  logic [KERNEL_SIZE_WIDTH-1:0] conf_k;
  logic [BEAT_CNT_WIDTH-1:0]    wpl_in, wpl_q;
  logic [ROW_CNT_WIDTH:0]       rows_in, rows_q;
  logic [KERNEL_SIZE_WIDTH-1:0] k_q;
  logic                         cfg_bad, start_acc, beat_inc, line_end;
  logic                         beat_last, kline_wrap, row_last;
  logic [BEAT_CNT_WIDTH-1:0]    beat_cnt;
  logic [KERNEL_SIZE_WIDTH-1:0] kline_cnt;
  logic [ROW_CNT_WIDTH-1:0]     row_cnt;
  logic                         unused_conf_bits;

  assign conf_w  = i_conf_inputshape[CONF_W_MSB:CONF_W_LSB];
  assign conf_h  = i_conf_inputshape[CONF_H_MSB:CONF_H_LSB];
  assign conf_k  = i_conf_kernelshape[CONF_K_LSB +: KERNEL_SIZE_WIDTH];
  assign wpl_in  = BEAT_CNT_WIDTH'(calc_words_per_line(conf_w));
  assign rows_in = (ROW_CNT_WIDTH + 1)'(conf_h) - (ROW_CNT_WIDTH + 1)'(conf_k)
                 + (ROW_CNT_WIDTH + 1)'(1);
  assign cfg_bad = (wpl_in == '0) || (conf_k == '0) || (conf_h < 8'(conf_k));

  assign unused_conf_bits = ^{i_conf_inputshape[REG_WIDTH-1:CONF_H_MSB+1],
                              i_conf_kernelshape[REG_WIDTH-1:KERNEL_SIZE_WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    beat_inc  = 1'b0;
    line_end  = 1'b0;
    o_req     = 1'b0;
    o_stall   = 1'b0;
    o_end     = 1'b0;
    o_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          start_acc = 1'b1;
          state_d   = cfg_bad ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        o_req    = 1'b1;
        o_stall  = i_fifo_full;
        beat_inc = ~i_fifo_full;
        if (beat_inc && beat_last) state_d = ST_LEND;
      end
      ST_LEND: begin
        o_end    = 1'b1;
        line_end = 1'b1;
        state_d  = (kline_wrap && row_last) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wpl_q  <= '0;
      k_q    <= '0;
      rows_q <= '0;
      o_err  <= 1'b0;
    end else if (start_acc) begin
      wpl_q  <= wpl_in;
      k_q    <= conf_k;
      rows_q <= rows_in;
      o_err  <= cfg_bad;
    end
  end

  data_req_ctrl_cnt #(
    .BEAT_CNT_WIDTH    (BEAT_CNT_WIDTH),
    .KERNEL_SIZE_WIDTH (KERNEL_SIZE_WIDTH),
    .ROW_CNT_WIDTH     (ROW_CNT_WIDTH)
  ) u_cnt (
    .clk            (clk),
    .rst            (rst),
    .clr            (start_acc),
    .beat_inc       (beat_inc),
    .line_end       (line_end),
    .words_per_line (wpl_q),
    .kernel_size    (k_q),
    .out_rows       (rows_q),
    .beat_cnt       (beat_cnt),
    .kline_cnt      (kline_cnt),
    .row_cnt        (row_cnt),
    .beat_last      (beat_last),
    .kline_wrap     (kline_wrap),
    .row_last       (row_last)
  );

  assign dbg_ctrl_state = REG_WIDTH'(state_q);
  assign dbg_ctrl_cnt   = REG_WIDTH'({row_cnt, kline_cnt, beat_cnt});

`ifdef DATA_REQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      o_perf_stall_cnt <= '0;
      o_perf_cycle_cnt <= '0;
    end else begin
      if (o_stall && (o_perf_stall_cnt != '1))
        o_perf_stall_cnt <= o_perf_stall_cnt + REG_WIDTH'(1);
      if (o_busy && (o_perf_cycle_cnt != '1))
        o_perf_cycle_cnt <= o_perf_cycle_cnt + REG_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_data_req_ctrl.sv
// Directed self-checking bench for data_req_ctrl; checks perf counters when
// DATA_REQ_CTRL_PERF_EN is defined.
module tb_data_req_ctrl;

  logic        clk = 1'b0;
  logic        rst, i_start, i_fifo_full;
  logic [31:0] i_conf_inputshape, i_conf_kernelshape;
  logic        o_req, o_stall, o_end, o_busy, o_done, o_err;
  logic [31:0] dbg_ctrl_state, dbg_ctrl_cnt;
`ifdef DATA_REQ_CTRL_PERF_EN
  logic [31:0] o_perf_stall_cnt, o_perf_cycle_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_req_ctrl #(
    .REG_WIDTH         (32),
    .KERNEL_SIZE_WIDTH (2),
    .BEAT_CNT_WIDTH    (10),
    .ROW_CNT_WIDTH     (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (i_start),
    .i_fifo_full        (i_fifo_full),
    .i_conf_inputshape  (i_conf_inputshape),
    .i_conf_kernelshape (i_conf_kernelshape),
    .o_req              (o_req),
    .o_stall            (o_stall),
    .o_end              (o_end),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_err              (o_err),
    .dbg_ctrl_state     (dbg_ctrl_state),
    .dbg_ctrl_cnt       (dbg_ctrl_cnt)
`ifdef DATA_REQ_CTRL_PERF_EN
    ,
    .o_perf_stall_cnt   (o_perf_stall_cnt),
    .o_perf_cycle_cnt   (o_perf_cycle_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses i_start with the given config, then observes one cycle at a time
  // (cycle 1 = first cycle after the start edge) until o_done or a 200-cycle budget.
  task automatic run_pass(input int w, input int h, input int k,
                          input int stall_lo, input int stall_hi, input int restart_cyc,
                          output int n_end, output int n_beat, output int n_req,
                          output int done_cyc, output int first_end, output int last_end,
                          output int stall_bad, output int err_at_done,
                          output int bc3, output int bc8, output int cnt10, output int cnt11);
    logic [7:0] wb, hb;
    wb = w[7:0];
    hb = h[7:0];
    n_end = 0; n_beat = 0; n_req = 0; done_cyc = -1; first_end = -1; last_end = -1;
    stall_bad = 0; err_at_done = -1; bc3 = -1; bc8 = -1; cnt10 = -1; cnt11 = -1;
    i_conf_inputshape  = {16'd0, hb, wb};
    i_conf_kernelshape = k;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      i_fifo_full = (c >= stall_lo) && (c <= stall_hi);
      if (c == restart_cyc) begin
        i_start = 1'b1;
        i_conf_inputshape[7:0] = 8'd4;
      end
      #1;
      if (o_req && (o_stall !== i_fifo_full)) stall_bad++;
      if (!o_req && o_stall) stall_bad++;
      if (o_req) n_req++;
      if (o_req && !o_stall) n_beat++;
      if (o_end) begin
        n_end++;
        if (first_end < 0) first_end = c;
        last_end = c;
      end
      if (c == 3)  bc3   = int'(dbg_ctrl_cnt[9:0]);
      if (c == 8)  bc8   = int'(dbg_ctrl_cnt[9:0]);
      if (c == 10) cnt10 = int'(dbg_ctrl_cnt);
      if (c == 11) cnt11 = int'(dbg_ctrl_cnt);
      if (o_done) begin
        done_cyc    = c;
        err_at_done = int'(o_err);
      end
      tick();
      i_start = 1'b0;
      i_fifo_full = 1'b0;
      i_conf_inputshape = {16'd0, hb, wb};
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_fifo_full = 1'b0;
    i_conf_inputshape = '0; i_conf_kernelshape = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({o_req, o_stall, o_end, o_busy, o_done, o_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000", {o_req, o_stall, o_end, o_busy, o_done, o_err});
    end
    n_checks++;
    if (dbg_ctrl_state !== 32'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_ctrl_state);
    end
    n_checks++;
    if (dbg_ctrl_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dbg_ctrl_cnt);
    end
    tick();
  endtask

  task automatic test_basic_pass();
    int ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11;
    run_pass(8, 4, 3, 0, -1, 0, ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11);
    n_checks++; if (ne !== 6)  begin n_fail++; $display("FAIL basic_end_count: got %0d expected 6", ne); end
    n_checks++; if (nb !== 36) begin n_fail++; $display("FAIL basic_beats: got %0d expected 36", nb); end
    n_checks++; if (fe !== 7)  begin n_fail++; $display("FAIL basic_first_end: got %0d expected 7", fe); end
    n_checks++; if (dc !== 43) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 43", dc); end
    n_checks++; if (le !== 42) begin n_fail++; $display("FAIL basic_last_end: got %0d expected 42", le); end
    n_checks++; if (ed !== 0)  begin n_fail++; $display("FAIL basic_err: got %0d expected 0", ed); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got %b expected 0", o_busy); end
  endtask

  task automatic test_stall();
    int ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11;
    run_pass(8, 4, 3, 3, 7, 0, ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11);
    n_checks++; if (sb !== 0)  begin n_fail++; $display("FAIL stall_mirror: got %0d bad cycles expected 0", sb); end
    n_checks++; if (b3 !== 2)  begin n_fail++; $display("FAIL stall_beat_at3: got %0d expected 2", b3); end
    n_checks++; if (b8 !== 2)  begin n_fail++; $display("FAIL stall_beat_held: got %0d expected 2", b8); end
    n_checks++; if (fe !== 12) begin n_fail++; $display("FAIL stall_first_end: got %0d expected 12", fe); end
    n_checks++; if (nb !== 36) begin n_fail++; $display("FAIL stall_beats: got %0d expected 36", nb); end
    n_checks++; if (dc !== 48) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 48", dc); end
`ifdef DATA_REQ_CTRL_PERF_EN
    n_checks++; if (o_perf_stall_cnt !== 32'd5)  begin n_fail++; $display("FAIL perf_stall: got %0d expected 5", o_perf_stall_cnt); end
    n_checks++; if (o_perf_cycle_cnt !== 32'd48) begin n_fail++; $display("FAIL perf_cycle: got %0d expected 48", o_perf_cycle_cnt); end
`endif
  endtask

  task automatic test_zero_words();
    int ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11;
    run_pass(1, 4, 3, 0, -1, 0, ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11);
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL zw_done_cycle: got %0d expected 1", dc); end
    n_checks++; if (ed !== 1) begin n_fail++; $display("FAIL zw_err_at_done: got %0d expected 1", ed); end
    n_checks++; if (nr !== 0 || ne !== 0) begin n_fail++; $display("FAIL zw_no_traffic: got req=%0d end=%0d expected 0 0", nr, ne); end
    n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL zw_err_sticky: got %b expected 1", o_err); end
    i_conf_inputshape = {16'd0, 8'd4, 8'd8};
    i_conf_kernelshape = 32'd3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL zw_err_clear: got %b expected 0", o_err); end
    n_checks++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL zw_restart_req: got %b expected 1", o_req); end
    for (int i = 0; i < 60 && o_busy; i++) tick();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL zw_restart_finish: got %b expected 0", o_busy); end
  endtask

  task automatic test_h_lt_k();
    int ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11;
    run_pass(8, 2, 3, 0, -1, 0, ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11);
    n_checks++; if (ed !== 1) begin n_fail++; $display("FAIL hk_err: got %0d expected 1", ed); end
    n_checks++; if (nr !== 0 || ne !== 0) begin n_fail++; $display("FAIL hk_no_traffic: got req=%0d end=%0d expected 0 0", nr, ne); end
  endtask

  task automatic test_restart_ignored();
    int ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11;
    run_pass(8, 4, 3, 0, -1, 10, ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11);
    n_checks++; if (c10 !== 1026) begin n_fail++; $display("FAIL rs_cnt10: got %0d expected 1026", c10); end
    n_checks++; if (c11 !== 1027) begin n_fail++; $display("FAIL rs_cnt11: got %0d expected 1027", c11); end
    n_checks++; if (nb !== 36 || ne !== 6) begin n_fail++; $display("FAIL rs_totals: got beats=%0d ends=%0d expected 36 6", nb, ne); end
    n_checks++; if (dc !== 43) begin n_fail++; $display("FAIL rs_done_cycle: got %0d expected 43", dc); end
  endtask

  task automatic test_mid_reset();
    int ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11;
    int stray;
    i_conf_inputshape = {16'd0, 8'd4, 8'd8};
    i_conf_kernelshape = 32'd3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (dbg_ctrl_cnt !== 32'd3) begin n_fail++; $display("FAIL mr_pre_cnt: got %0d expected 3", dbg_ctrl_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({o_req, o_busy} !== 2'b00 || dbg_ctrl_state !== 32'd0) begin
      n_fail++; $display("FAIL mr_abort: got req=%b busy=%b state=%0d expected 0 0 0", o_req, o_busy, dbg_ctrl_state);
    end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_end || o_done) stray++;
      tick();
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL mr_no_end_done: got %0d expected 0", stray); end
    run_pass(8, 4, 3, 0, -1, 0, ne, nb, nr, dc, fe, le, sb, ed, b3, b8, c10, c11);
    n_checks++; if (nb !== 36 || ne !== 6 || dc !== 43) begin
      n_fail++; $display("FAIL mr_followup: got beats=%0d ends=%0d done=%0d expected 36 6 43", nb, ne, dc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_stall();
    test_zero_words();
    test_h_lt_k();
    test_restart_ignored();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
